// File: rtl/tiro_inimigo.sv
// Enemy fire: picks a pseudo-random live enemy, drops one bullet at a time and flags ship hits.
// Optional macro TIRO_MIRADO_EN: bullet drifts 1 px per movement tick toward the ship centre.
module tiro_inimigo #(
  parameter int          N_INIMIGOS = 8,
  parameter int          INTERVALO  = 40,
  parameter int          VEL        = 4,
  parameter int          LARG_NAVE  = 33,
  parameter int          ALT_NAVE   = 24,
  parameter logic [15:0] SEMENTE    = 16'hACE1
) (
  input  logic                    CLOCK_50,
  input  logic                    resetInimigo,
  input  logic                    pausa,
  input  logic                    tick_mv,
  input  logic [10*N_INIMIGOS-1:0] inimigos_x,
  input  logic [10*N_INIMIGOS-1:0] inimigos_y,
  input  logic [N_INIMIGOS-1:0]   inimigos_vivo,
  input  logic [9:0]              nave_x,
  input  logic [9:0]              nave_y,
  output logic [9:0]              tiro_x,
  output logic [9:0]              tiro_y,
  output logic                    tiro_ativo,
  output logic                    acertou_nave
);

  localparam int               CW       = (INTERVALO > 1) ? $clog2(INTERVALO) : 1;
  localparam logic [CW-1:0]    CD_MAX   = CW'(INTERVALO - 1);
  localparam logic [4:0]       IDX_MAX  = 5'(N_INIMIGOS - 1);
  localparam logic [5:0]       SCAN_MAX = 6'(N_INIMIGOS - 1);

  typedef enum logic [1:0] {OCIOSO, ESCOLHE, VOO, ACERTO} estado_t;

  estado_t       estado;
  logic [CW-1:0] cooldown;
  logic [15:0]   lfsr;
  logic [4:0]    idx;
  logic [5:0]    scan;

  logic [9:0]    x_sel;
  logic [9:0]    y_sel;
  logic          vivo_sel;
  logic [10:0]   tx11;
  logic [10:0]   ty11;
  logic          acerto_cond;
  logic          sai_tela;
  logic [4:0]    idx_inicial;

  // Mux of the current candidate; constant part-selects keep indexing lint-clean
  always_comb begin
    x_sel    = '0;
    y_sel    = '0;
    vivo_sel = 1'b0;
    for (int k = 0; k < N_INIMIGOS; k++) begin
      if (idx == 5'(k)) begin
        x_sel    = inimigos_x[10*k +: 10];
        y_sel    = inimigos_y[10*k +: 10];
        vivo_sel = inimigos_vivo[k];
      end
    end
  end

  assign tx11        = {1'b0, tiro_x};
  assign ty11        = {1'b0, tiro_y};
  assign acerto_cond = ({1'b0, nave_x} <= tx11) && (tx11 < ({1'b0, nave_x} + 11'(LARG_NAVE))) &&
                       ({1'b0, nave_y} <= ty11) && (ty11 < ({1'b0, nave_y} + 11'(ALT_NAVE)));
  assign sai_tela    = (ty11 + 11'(VEL)) >= 11'd480;
  assign idx_inicial = 5'({1'b0, lfsr[4:0]} % 6'(N_INIMIGOS));

`ifdef TIRO_MIRADO_EN
  logic [10:0] alvo_x;
  logic [9:0]  passo_x;
  assign alvo_x = {1'b0, nave_x} + 11'(LARG_NAVE / 2);
  always_comb begin
    passo_x = tiro_x;
    if (tx11 < alvo_x)      passo_x = tiro_x + 10'd1;
    else if (tx11 > alvo_x) passo_x = tiro_x - 10'd1;
  end
`endif

  // Single FSM; the LFSR free-runs even while paused so selection stays unpredictable
  always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
    if (resetInimigo) begin
      estado       <= OCIOSO;
      cooldown     <= '0;
      lfsr         <= SEMENTE;
      idx          <= '0;
      scan         <= '0;
      tiro_x       <= '0;
      tiro_y       <= '0;
      tiro_ativo   <= 1'b0;
      acertou_nave <= 1'b0;
    end else begin
      lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      acertou_nave <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (tick_mv && !pausa) begin
            if (cooldown == CD_MAX) begin
              cooldown <= '0;
              idx      <= idx_inicial;
              scan     <= '0;
              estado   <= ESCOLHE;
            end else begin
              cooldown <= cooldown + 1'b1;
            end
          end
        end
        ESCOLHE: begin
          if (!pausa) begin
            if (vivo_sel) begin
              tiro_x     <= x_sel + 10'd16;
              tiro_y     <= y_sel + 10'd24;
              tiro_ativo <= 1'b1;
              estado     <= VOO;
            end else if (scan == SCAN_MAX) begin
              estado <= OCIOSO;
            end else begin
              idx  <= (idx == IDX_MAX) ? 5'd0 : idx + 5'd1;
              scan <= scan + 6'd1;
            end
          end
        end
        VOO: begin
          // Hit takes priority over leaving the screen or moving
          if (!pausa) begin
            if (acerto_cond) begin
              tiro_ativo   <= 1'b0;
              acertou_nave <= 1'b1;
              estado       <= ACERTO;
            end else if (tick_mv) begin
              if (sai_tela) begin
                tiro_ativo <= 1'b0;
                estado     <= OCIOSO;
              end else begin
                tiro_y <= tiro_y + 10'(VEL);
`ifdef TIRO_MIRADO_EN
                tiro_x <= passo_x;
`endif
              end
            end
          end
        end
        ACERTO: begin
          estado <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiro_inimigo.sv
// Directed bench for tiro_inimigo with a scoreboard queue of expected bullet outputs.
// Follows TIRO_MIRADO_EN in its horizontal model so it matches either build.
module tb_tiro_inimigo;

  logic        CLOCK_50 = 1'b0;
  logic        resetInimigo = 1'b1;
  logic        pausa = 1'b0;
  logic        tick_mv = 1'b0;
  logic [39:0] inimigos_x = '0;
  logic [39:0] inimigos_y = '0;
  logic [3:0]  inimigos_vivo = '0;
  logic [9:0]  nave_x = 10'd900;
  logic [9:0]  nave_y = 10'd0;
  logic [9:0]  tiro_x;
  logic [9:0]  tiro_y;
  logic        tiro_ativo;
  logic        acertou_nave;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       ativo;
    logic       hit;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [9:0] xExp = '0;
  logic [9:0] yExp = '0;

  tiro_inimigo #(.N_INIMIGOS(4), .INTERVALO(3), .VEL(4)) dut (
    .CLOCK_50(CLOCK_50), .resetInimigo(resetInimigo), .pausa(pausa), .tick_mv(tick_mv),
    .inimigos_x(inimigos_x), .inimigos_y(inimigos_y), .inimigos_vivo(inimigos_vivo),
    .nave_x(nave_x), .nave_y(nave_y), .tiro_x(tiro_x), .tiro_y(tiro_y),
    .tiro_ativo(tiro_ativo), .acertou_nave(acertou_nave)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic pushExp(input logic [9:0] x, input logic [9:0] y, input logic a, input logic h);
    exp_t e;
    e.x = x; e.y = y; e.ativo = a; e.hit = h;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (tiro_x === e.x) else begin failures++; $error("FAIL %s tiro_x observed=%0d expected=%0d", tag, tiro_x, e.x); end
    checks++;
    assert (tiro_y === e.y) else begin failures++; $error("FAIL %s tiro_y observed=%0d expected=%0d", tag, tiro_y, e.y); end
    checks++;
    assert (tiro_ativo === e.ativo) else begin failures++; $error("FAIL %s tiro_ativo observed=%b expected=%b", tag, tiro_ativo, e.ativo); end
    checks++;
    assert (acertou_nave === e.hit) else begin failures++; $error("FAIL %s acertou_nave observed=%b expected=%b", tag, acertou_nave, e.hit); end
  endtask

  task automatic applyStimulus(input int nTicks);
    for (int i = 0; i < nTicks; i++) begin
      @(negedge CLOCK_50) tick_mv = 1'b1;
      @(negedge CLOCK_50) tick_mv = 1'b0;
    end
  endtask

  function automatic logic [9:0] passoX(input logic [9:0] x);
`ifdef TIRO_MIRADO_EN
    int t;
    t = int'(nave_x) + 16;
    if (int'(x) < t) return x + 10'd1;
    if (int'(x) > t) return x - 10'd1;
`endif
    return x;
  endfunction

  task automatic flyTick(input string tag);
    applyStimulus(1);
    xExp = passoX(xExp);
    yExp = yExp + 10'd4;
    pushExp(xExp, yExp, 1'b1, 1'b0);
    checkOutput(tag);
  endtask

  // Bounded wait for the launch; an expired bound shows up as an ativo failure
  task automatic waitShot();
    int n;
    n = 0;
    while (tiro_ativo !== 1'b1 && n < 6) begin
      @(negedge CLOCK_50);
      n++;
    end
  endtask

  task automatic setInimigo2(input logic [9:0] x, input logic [9:0] y);
    inimigos_x[29:20] = x;
    inimigos_y[29:20] = y;
  endtask

  initial begin
    inimigos_x = {10'd300, 10'd0, 10'd20, 10'd10};
    inimigos_y = {10'd60, 10'd0, 10'd40, 10'd30};
    repeat (2) @(negedge CLOCK_50);
    pushExp(10'd0, 10'd0, 1'b0, 1'b0);
    checkOutput("reset");
    resetInimigo = 1'b0;

    setInimigo2(10'd100, 10'd50);
    inimigos_vivo = 4'b0100;
    applyStimulus(2);
    pausa = 1'b1;
    applyStimulus(5);
    repeat (6) @(negedge CLOCK_50);
    pushExp(10'd0, 10'd0, 1'b0, 1'b0);
    checkOutput("cooldown_frozen");
    pausa = 1'b0;
    applyStimulus(1);
    xExp = 10'd116; yExp = 10'd74;
    pushExp(xExp, yExp, 1'b1, 1'b0);
    waitShot();
    checkOutput("spawn_a");
    while (int'(yExp) + 4 < 480) flyTick("voo_a");
    applyStimulus(1);
    pushExp(xExp, yExp, 1'b0, 1'b0);
    checkOutput("saida_478");

    inimigos_vivo = 4'b0000;
    applyStimulus(3);
    repeat (4) @(negedge CLOCK_50);
    inimigos_vivo = 4'b0100;
    setInimigo2(10'd100, 10'd76);
    repeat (10) @(negedge CLOCK_50);
    pushExp(xExp, yExp, 1'b0, 1'b0);
    checkOutput("scan_morto");
    applyStimulus(2);
    repeat (6) @(negedge CLOCK_50);
    pushExp(xExp, yExp, 1'b0, 1'b0);
    checkOutput("cooldown_reinicia");
    applyStimulus(1);
    xExp = 10'd116; yExp = 10'd100;
    pushExp(xExp, yExp, 1'b1, 1'b0);
    waitShot();
    checkOutput("spawn_b");
    repeat (25) flyTick("voo_b");

    pausa = 1'b1;
    applyStimulus(50);
    pushExp(xExp, 10'd200, 1'b1, 1'b0);
    checkOutput("pausa_voo");
    pausa = 1'b0;
    flyTick("retoma");
    repeat (24) flyTick("voo_c");

    @(negedge CLOCK_50);
    #2 resetInimigo = 1'b1;
    #1 xExp = '0; yExp = '0;
    pushExp(xExp, yExp, 1'b0, 1'b0);
    checkOutput("reset_voo");
    @(negedge CLOCK_50) resetInimigo = 1'b0;

    setInimigo2(10'd200, 10'd290);
    nave_x = 10'd200; nave_y = 10'd330;
    applyStimulus(2);
    repeat (6) @(negedge CLOCK_50);
    pushExp(10'd0, 10'd0, 1'b0, 1'b0);
    checkOutput("reset_cooldown");
    applyStimulus(1);
    xExp = 10'd216; yExp = 10'd314;
    pushExp(xExp, yExp, 1'b1, 1'b0);
    waitShot();
    checkOutput("spawn_c");
    repeat (4) flyTick("aproxima");
    @(negedge CLOCK_50);
    pushExp(xExp, 10'd330, 1'b0, 1'b1);
    checkOutput("acerto");
    @(negedge CLOCK_50);
    pushExp(xExp, 10'd330, 1'b0, 1'b0);
    checkOutput("pulso_unico");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
